lreport: RTL

LREPORT -- requirements
Module: lreport

---
 rtl/lreport.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lreport.sv
// lreport: buffers the lupdate-bound word stream in a 32-deep FWFT FIFO and, on a
// periodic timer, inserts a 5-word status report between forwarded packets.
module lreport #(
    parameter logic [7:0]  LMID          = 8'd12,
    parameter logic [31:0] REPORT_PERIOD = 32'd125000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_lr_data,
    input  logic         in_lr_data_wr,
    input  logic         in_lr_data_valid,
    input  logic         in_lr_data_valid_wr,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  in_controller_mac,
    input  logic         in_report_en,
    input  logic [31:0]  in_time_slot_period,
    input  logic         in_direction,
    input  logic [31:0]  in_token_bucket_para,
    input  logic [47:0]  in_direct_mac_addr,
    output logic [133:0] out_lr_data,
    output logic         out_lr_data_wr,
    output logic         out_lr_data_valid,
    output logic         out_lr_data_valid_wr
);

    localparam int unsigned Depth    = 32;
    localparam logic [1:0]  TypeHead = 2'b01;
    localparam logic [1:0]  TypeMid  = 2'b11;
    localparam logic [1:0]  TypeTail = 2'b10;

    typedef enum logic [1:0] {StIdle, StFwd, StRpt} state_e;

    // FIFO storage and pointers
    logic [135:0] fifo_mem_q [Depth];
    logic [4:0]   wr_ptr_q, wr_ptr_d;
    logic [4:0]   rd_ptr_q, rd_ptr_d;
    logic [5:0]   fifo_cnt_q, fifo_cnt_d;
    logic         fifo_empty;
    logic         fifo_full;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_drop;
    logic [135:0] fifo_head;
    logic [1:0]   head_type;

    // Counters and report timer
    logic [31:0]  rx_pkt_cnt_q, rx_pkt_cnt_d;
    logic [15:0]  ovf_cnt_q, ovf_cnt_d;
    logic [7:0]   report_seq_q, report_seq_d;
    logic [31:0]  timer_q, timer_d;
    logic         timer_expire;
    logic         pending_q, pending_d;
    logic         rpt_done;

    // State machine and registered outputs
    state_e       state_q, state_d;
    logic [2:0]   rpt_cnt_q, rpt_cnt_d;
    logic [133:0] rpt_word;
    logic [133:0] out_data_q, out_data_d;
    logic         out_wr_q, out_wr_d;
    logic         out_valid_q, out_valid_d;
    logic         out_valid_wr_q, out_valid_wr_d;

    assign fifo_empty = (fifo_cnt_q == 6'd0);
    assign fifo_full  = (fifo_cnt_q == 6'(Depth));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign head_type  = fifo_head[133:132];
    // A pop in the same cycle frees a slot, so a write at full occupancy still lands.
    assign fifo_push  = in_lr_data_wr && (!fifo_full || fifo_pop);
    assign fifo_drop  = in_lr_data_wr && fifo_full && !fifo_pop;

    always_comb begin
        wr_ptr_d   = fifo_push ? wr_ptr_q + 5'd1 : wr_ptr_q;
        rd_ptr_d   = fifo_pop ? rd_ptr_q + 5'd1 : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 6'd1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= {in_lr_data_valid_wr, in_lr_data_valid, in_lr_data};
        end
    end

    assign timer_expire = in_report_en && (timer_q == REPORT_PERIOD - 32'd1);

    always_comb begin
        rx_pkt_cnt_d = rx_pkt_cnt_q;
        if (fifo_push && (in_lr_data[133:132] == TypeHead)) begin
            rx_pkt_cnt_d = rx_pkt_cnt_q + 32'd1;
        end
        ovf_cnt_d = ovf_cnt_q;
        if (fifo_drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        if (!in_report_en || timer_expire) begin
            timer_d = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        // An expiry on the report's last word is absorbed by the report being finished.
        pending_d = pending_q;
        if (rpt_done) begin
            pending_d = 1'b0;
        end else if (timer_expire) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        rpt_word = '0;
        case (rpt_cnt_q)
            3'd0: rpt_word = {TypeHead, 4'h0, LMID, 120'b0};
            3'd1: rpt_word = {TypeMid, 4'h0, 128'b0};
            3'd2: rpt_word = {TypeMid, 4'h0, in_controller_mac, in_local_mac_id, 16'h1662,
                              4'h0, 4'he, report_seq_q};
            3'd3: rpt_word = {TypeMid, 4'h0, in_direct_mac_addr, in_direction, 15'b0,
                              in_token_bucket_para, in_time_slot_period};
            3'd4: rpt_word = {TypeTail, 4'h0, rx_pkt_cnt_q, 16'b0, ovf_cnt_q, 64'b0};
            default: rpt_word = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        rpt_cnt_d      = rpt_cnt_q;
        report_seq_d   = report_seq_q;
        fifo_pop       = 1'b0;
        rpt_done       = 1'b0;
        out_data_d     = '0;
        out_wr_d       = 1'b0;
        out_valid_d    = 1'b0;
        out_valid_wr_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d   = StRpt;
                    rpt_cnt_d = 3'd0;
                end else if (!fifo_empty) begin
                    // Non-head words here are orphans from a dropped or aborted packet.
                    fifo_pop = 1'b1;
                    if (head_type == TypeHead) begin
                        out_data_d     = fifo_head[133:0];
                        out_wr_d       = 1'b1;
                        out_valid_d    = fifo_head[134];
                        out_valid_wr_d = fifo_head[135];
                        state_d        = StFwd;
                    end
                end
            end
            StFwd: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    out_data_d     = fifo_head[133:0];
                    out_wr_d       = 1'b1;
                    out_valid_d    = fifo_head[134];
                    out_valid_wr_d = fifo_head[135];
                    if (head_type == TypeTail) begin
                        state_d = StIdle;
                    end
                end
            end
            StRpt: begin
                out_data_d = rpt_word;
                out_wr_d   = 1'b1;
                if (rpt_cnt_q == 3'd4) begin
                    out_valid_d    = 1'b1;
                    out_valid_wr_d = 1'b1;
                    rpt_done       = 1'b1;
                    report_seq_d   = report_seq_q + 8'd1;
                    rpt_cnt_d      = 3'd0;
                    state_d        = StIdle;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            rx_pkt_cnt_q   <= '0;
            ovf_cnt_q      <= '0;
            report_seq_q   <= '0;
            timer_q        <= '0;
            pending_q      <= 1'b0;
            state_q        <= StIdle;
            rpt_cnt_q      <= '0;
            out_data_q     <= '0;
            out_wr_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            rx_pkt_cnt_q   <= rx_pkt_cnt_d;
            ovf_cnt_q      <= ovf_cnt_d;
            report_seq_q   <= report_seq_d;
            timer_q        <= timer_d;
            pending_q      <= pending_d;
            state_q        <= state_d;
            rpt_cnt_q      <= rpt_cnt_d;
            out_data_q     <= out_data_d;
            out_wr_q       <= out_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
        end
    end

    assign out_lr_data          = out_data_q;
    assign out_lr_data_wr       = out_wr_q;
    assign out_lr_data_valid    = out_valid_q;
    assign out_lr_data_valid_wr = out_valid_wr_q;

endmodule
